mem_write_monitor: RTL and testbench

- Synthesisable, parametrised self-check engine for the single-cycle MIPS computer's data-memory write port.
- Holds a table of DEPTH expected (address, data) stores and watches memwrite/dataadr/writedata each cycle.
- Raises pass when every valid entry has been satisfied, or fail on a wrong-data store or a timeout.
- Sits beside the computer in benches and on-board self-test; supports ordered and unordered checking.

---
 rtl/mem_write_monitor_pkg.sv | 23 ++
 rtl/mwm_table.sv | 52 +++++
 rtl/mem_write_monitor.sv | 179 +++++++++++++++++
 tb/tb_mem_write_monitor.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the data-memory write monitor: FSM state and failure codes.
// The optional logging in the top module is controlled by MEM_WRITE_MONITOR_LOG_EN.
package mem_write_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mwm_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'b00,
        WRONG_DATA = 2'b01,
        TIMEOUT    = 2'b10
    } mwm_fail_t;

    // An index needs at least one bit, even for a single-entry table.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mwm_table.sv
// Expected-store register file with one write port and per-entry compares
// against the monitored store address/data.
module mwm_table
    import mem_write_monitor_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int A     = 32,
    parameter  int DEPTH = 4,
    localparam int IW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [A-1:0]     addr,
    input  logic [N-1:0]     data,
    input  logic             valid_in,
    input  logic [A-1:0]     mon_addr,
    input  logic [N-1:0]     mon_data,
    output logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] addr_match,
    output logic [DEPTH-1:0] data_match
);

    logic [A-1:0] addr_q [DEPTH];
    logic [N-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (we && (int'(idx) < DEPTH)) begin
            valid[idx] <= valid_in;
        end
    end

    // NOTE: the address/data storage is deliberately not reset; the valid bits alone decide whether an entry is used.
    always_ff @(posedge clk) begin
        if (we && (int'(idx) < DEPTH)) begin
            addr_q[idx] <= addr;
            data_q[idx] <= data;
        end
    end

    // Address match is qualified by valid so callers never see stale entries.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_match[i] = valid[i] && (addr_q[i] == mon_addr);
            data_match[i] = (data_q[i] == mon_data);
        end
    end

endmodule

// File: rtl/mem_write_monitor.sv
// Self-check engine for the data-memory write port: ordered/unordered matching, pass/fail/timeout.
// Define MEM_WRITE_MONITOR_LOG_EN to get simulation-only $display logging of hits and results.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int A     = 32,
    parameter  int DEPTH = 4,
    parameter  int TW    = 16,
    localparam int IW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [A-1:0]     cfg_addr,
    input  logic [N-1:0]     cfg_data,
    input  logic             cfg_valid,
    input  logic             ordered,
    input  logic [TW-1:0]    timeout_limit,
    input  logic             start,
    input  logic             memwrite,
    input  logic [A-1:0]     dataadr,
    input  logic [N-1:0]     writedata,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [DEPTH-1:0] hit_mask,
    output logic [IW-1:0]    fail_idx
);

    mwm_state_t       state;
    logic             ordered_q;
    logic [TW-1:0]    limit_q;
    logic [TW-1:0]    count;
    logic [TW-1:0]    count_next;
    logic [IW:0]      ptr;
    logic [IW:0]      ptr_next;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] addr_match;
    logic [DEPTH-1:0] data_match;
    logic [DEPTH-1:0] hit_next;
    logic [IW-1:0]    cur_idx;
    logic             cur_found;
    logic             store;
    logic             wrong;
    logic             covered;
    logic             timed_out;

    mwm_table #(.N(N), .A(A), .DEPTH(DEPTH)) u_table (
        .clk        (clk),
        .reset      (reset),
        .we         (cfg_we && (state == IDLE)),
        .idx        (cfg_idx),
        .addr       (cfg_addr),
        .data       (cfg_data),
        .valid_in   (cfg_valid),
        .mon_addr   (dataadr),
        .mon_data   (writedata),
        .valid      (valid),
        .addr_match (addr_match),
        .data_match (data_match)
    );

    // First valid entry at or beyond the order pointer.
    always_comb begin
        cur_found = 1'b0;
        cur_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (i >= int'(ptr))) begin
                cur_found = 1'b1;
                cur_idx   = IW'(i);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        store    = (state == RUN) && memwrite;
        hit_next = hit_mask;
        ptr_next = ptr;
        wrong    = 1'b0;
        if (store) begin
            if (ordered_q) begin
                if (cur_found && addr_match[cur_idx]) begin
                    if (data_match[cur_idx]) begin
                        hit_next[cur_idx] = 1'b1;
                        ptr_next          = {1'b0, cur_idx} + 1'b1;
                    end else begin
                        wrong = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (addr_match[i]) hit_next[i] = data_match[i];
                end
            end
        end
        covered    = ((hit_next & valid) == valid);
        count_next = (count == '1) ? count : count + 1'b1;
        timed_out  = (limit_q != '0) && (count_next == limit_q);
    end

    // NOTE: all state here uses non-blocking assignment so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ordered_q <= 1'b0;
            limit_q   <= '0;
            count     <= '0;
            ptr       <= '0;
            hit_mask  <= '0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= NONE;
            fail_idx  <= '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        state     <= RUN;
                        ordered_q <= ordered;
                        limit_q   <= timeout_limit;
                        count     <= '0;
                        ptr       <= '0;
                        hit_mask  <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_code <= NONE;
                        fail_idx  <= '0;
                    end
                end
                RUN: begin
                    count    <= count_next;
                    ptr      <= ptr_next;
                    hit_mask <= hit_next;
                    if (covered) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                    end else if (wrong) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= WRONG_DATA;
                        fail_idx  <= cur_idx;
                    end else if (timed_out) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fail_code <= TIMEOUT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_WRITE_MONITOR_LOG_EN
    always @(posedge clk) begin
        if (reset && (state == RUN)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_next[i] && !hit_mask[i])
                    $display("%0t mwm: hit idx=%0d addr=%h data=%h", $time, i, dataadr, writedata);
            end
            if (covered)
                $display("%0t mwm: pass", $time);
            else if (wrong)
                $display("%0t mwm: fail code=01 idx=%0d addr=%h data=%h", $time, cur_idx, dataadr, writedata);
            else if (timed_out)
                $display("%0t mwm: fail code=10 idx=%0d addr=%h data=%h", $time, cur_idx, dataadr, writedata);
        end
    end
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Self-checking bench: directed scenarios plus randomized runs against a queue-based reference model.
module tb_mem_write_monitor;
    import mem_write_monitor_pkg::*;

    localparam int N     = 32;
    localparam int A     = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 16;
    localparam int IW    = 2;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [A-1:0]     cfg_addr;
    logic [N-1:0]     cfg_data;
    logic             cfg_valid;
    logic             ordered;
    logic [TW-1:0]    timeout_limit;
    logic             start;
    logic             memwrite;
    logic [A-1:0]     dataadr;
    logic [N-1:0]     writedata;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [DEPTH-1:0] hit_mask;
    logic [IW-1:0]    fail_idx;

    mem_write_monitor #(.N(N), .A(A), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .ordered       (ordered),
        .timeout_limit (timeout_limit),
        .start         (start),
        .memwrite      (memwrite),
        .dataadr       (dataadr),
        .writedata     (writedata),
        .busy          (busy),
        .pass          (pass),
        .fail          (fail),
        .fail_code     (fail_code),
        .hit_mask      (hit_mask),
        .fail_idx      (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected table, pending-order queue and result flags.
    logic [A-1:0] t_addr [DEPTH];
    logic [N-1:0] t_data [DEPTH];
    bit           t_valid[DEPTH];
    bit           m_idle, m_busy, m_pass, m_fail, m_ordered;
    bit           m_hit[DEPTH];
    int           m_code, m_fidx, m_count, m_limit;
    int           pending[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            t_valid[i] = 0;
            m_hit[i]   = 0;
        end
        m_idle = 1; m_busy = 0; m_pass = 0; m_fail = 0; m_ordered = 0;
        m_code = 0; m_fidx = 0; m_count = 0; m_limit = 0;
        pending.delete();
    endfunction

    function automatic logic [DEPTH-1:0] hit_vec();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_hit[i];
        return v;
    endfunction

    // One rising edge of the reference model, using the inputs the DUT samples.
    function automatic void model_step();
        bit all_hit;
        bit wrong;
        int wrong_i;
        if (m_idle && cfg_we) begin
            t_addr[cfg_idx]  = cfg_addr;
            t_data[cfg_idx]  = cfg_data;
            t_valid[cfg_idx] = cfg_valid;
        end
        if (!m_busy) begin
            if (start) begin
                m_idle = 0; m_busy = 1; m_pass = 0; m_fail = 0;
                m_code = 0; m_fidx = 0; m_count = 0;
                m_ordered = ordered;
                m_limit   = int'(timeout_limit);
                pending.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    m_hit[i] = 0;
                    if (t_valid[i]) pending.push_back(i);
                end
            end
        end else begin
            wrong = 0;
            wrong_i = 0;
            if (m_count < (1 << TW) - 1) m_count++;
            if (memwrite) begin
                if (m_ordered) begin
                    if (pending.size() > 0 && t_addr[pending[0]] == dataadr) begin
                        if (t_data[pending[0]] == writedata) begin
                            m_hit[pending[0]] = 1;
                            void'(pending.pop_front());
                        end else begin
                            wrong = 1;
                            wrong_i = pending[0];
                        end
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++)
                        if (t_valid[i] && t_addr[i] == dataadr) m_hit[i] = (t_data[i] == writedata);
                end
            end
            all_hit = 1;
            for (int i = 0; i < DEPTH; i++)
                if (t_valid[i] && !m_hit[i]) all_hit = 0;
            if (all_hit) begin
                m_busy = 0; m_pass = 1;
            end else if (wrong) begin
                m_busy = 0; m_fail = 1; m_code = 1; m_fidx = wrong_i;
            end else if (m_limit != 0 && m_count == m_limit) begin
                m_busy = 0; m_fail = 1; m_code = 2;
            end
        end
    endfunction

    task automatic compare_all();
        check("busy", busy, m_busy);
        check("pass", pass, m_pass);
        check("fail", fail, m_fail);
        check("fail_code", fail_code, m_code);
        check("hit_mask", hit_mask, hit_vec());
        check("fail_idx", fail_idx, m_fidx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_valid = 0;
        ordered = 0; timeout_limit = '0; start = 0;
        memwrite = 0; dataadr = '0; writedata = '0;
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cfg(input int idx, input int addr, input int data, input bit v);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_addr = A'(addr); cfg_data = N'(data); cfg_valid = v;
        tick();
        cfg_we = 0;
    endtask

    task automatic start_run(input bit ord, input int lim);
        start = 1; ordered = ord; timeout_limit = TW'(lim);
        tick();
        start = 0;
    endtask

    task automatic do_store(input int addr, input int data);
        memwrite = 1; dataadr = A'(addr); writedata = N'(data);
        tick();
        memwrite = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Ordered happy path with scratch traffic first.
        cfg(0, 84, 'h96, 1);
        start_run(1, 0);
        check("t1_busy", busy, 1);
        do_store(80, 'h11);
        check("t1_scratch_busy", busy, 1);
        do_store(84, 'h96);
        check("t1_pass", pass, 1);
        check("t1_hit", hit_mask, 4'b0001);
        check("t1_fail", fail, 0);

        // Ordered wrong data on entry 0.
        do_reset();
        cfg(0, 84, 'h96, 1);
        cfg(1, 88, 'h07, 1);
        start_run(1, 0);
        do_store(84, 'h95);
        check("t2_fail", fail, 1);
        check("t2_code", fail_code, 2'b01);
        check("t2_idx", fail_idx, 0);
        check("t2_busy", busy, 0);

        // Ordered, out-of-order store ignored until its turn.
        start_run(1, 0);
        do_store(88, 'h07);
        do_store(84, 'h96);
        check("t3_hit", hit_mask, 4'b0001);
        check("t3_busy", busy, 1);
        do_store(88, 'h07);
        check("t3_pass", pass, 1);

        // Unordered: last write wins.
        start_run(0, 0);
        do_store(84, 'h01);
        check("t4_hit0", hit_mask, 4'b0000);
        do_store(88, 'h07);
        check("t4_hit1", hit_mask, 4'b0010);
        do_store(84, 'h96);
        check("t4_hit2", hit_mask, 4'b0011);
        check("t4_pass", pass, 1);
        check("t4_nofail", fail, 0);

        // Timeout exactly limit cycles after RUN entry; limit 0 never times out.
        start_run(1, 10);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 10) check("t5_wait", fail, 0);
        end
        check("t5_fail", fail, 1);
        check("t5_code", fail_code, 2'b10);
        start_run(1, 0);
        repeat (40) tick();
        check("t5_nolimit_busy", busy, 1);

        // Reset in the middle of a run, then an empty-table run.
        do_reset();
        cfg(0, 84, 'h96, 1);
        cfg(1, 88, 'h07, 1);
        start_run(1, 0);
        do_store(84, 'h96);
        tick();
        check("t6_prehit", hit_mask, 4'b0001);
        reset = 1'b0;
        model_reset();
        #1;
        check("t6_busy", busy, 0);
        check("t6_hit", hit_mask, 0);
        check("t6_pass", pass, 0);
        check("t6_fail", fail, 0);
        check("t6_code", fail_code, 0);
        @(negedge clk);
        reset = 1'b1;
        start_run(1, 0);
        check("t6_run", busy, 1);
        tick();
        check("t6_empty_pass", pass, 1);
        check("t6_empty_busy", busy, 0);

        // Randomized runs with small address/data pools so matches are frequent.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++)
                cfg(i, 80 + 4 * $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            start_run($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 30));
            for (int c = 0; c < 50; c++) begin
                int j;
                j = $urandom_range(0, DEPTH - 1);
                memwrite = $urandom_range(0, 1);
                if ($urandom_range(0, 1) == 1) begin
                    dataadr   = t_addr[j];
                    writedata = ($urandom_range(0, 3) == 0) ? t_data[j] ^ 1 : t_data[j];
                end else begin
                    dataadr   = A'(80 + 4 * $urandom_range(0, 4));
                    writedata = N'($urandom_range(0, 3));
                end
                cfg_we    = ($urandom_range(0, 7) == 0);
                cfg_idx   = IW'($urandom_range(0, DEPTH - 1));
                cfg_addr  = A'(80 + 4 * $urandom_range(0, 3));
                cfg_data  = N'($urandom_range(0, 3));
                cfg_valid = $urandom_range(0, 1);
                start     = ($urandom_range(0, 15) == 0);
                ordered   = $urandom_range(0, 1);
                timeout_limit = TW'($urandom_range(0, 20));
                tick();
                clear_inputs();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
